tx_stream_arb: RTL and testbench

- Two-requester frame arbiter in front of the streaming MAC user write interface (tx_data/tx_eof/tx_we/tx_stop).
- Grants one source at a time and holds the grant for a whole frame, so frames never interleave in the TX FIFO.
- Enforces a maximum frame length. An overlong frame is truncated with a forced EOF, and the rest of that frame is drained and discarded.

---
 rtl/tx_stream_arb.sv | 120 ++++++++++++
 tb/tb_tx_stream_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tx_stream_arb.sv
// tx_stream_arb: two-source frame arbiter with max-length truncation in front of the MAC write port
module tx_stream_arb #(
  parameter int MAX_WORDS = 375,
  parameter logic [3:0] FORCE_EOF = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        strict_prio,
  input  logic [31:0] src0_data,
  input  logic [3:0]  src0_eof,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [31:0] src1_data,
  input  logic [3:0]  src1_eof,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_eof,
  output logic        tx_we,
  input  logic        tx_stop,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [7:0]  trunc_cnt
);
  localparam int WW = (MAX_WORDS > 2) ? $clog2(MAX_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic last_q, last_d;
  logic [WW-1:0] wc_q, wc_d;
  logic [15:0] fc0_q, fc0_d, fc1_q, fc1_d;
  logic [7:0] tc_q, tc_d;
  logic sel, sel_valid, win1, rdy, take, trunc, done;
  logic [31:0] sel_data;
  logic [3:0] sel_eof;
  assign sel = grant_q[1];
  assign sel_data = sel ? src1_data : src0_data;
  assign sel_eof = sel ? src1_eof : src0_eof;
  assign sel_valid = sel ? src1_valid : src0_valid;
  assign win1 = (src0_valid & src1_valid) ? (~strict_prio & ~last_q) : src1_valid;
  // arbitration, frame tracking and truncation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    wc_d = wc_q;
    fc0_d = fc0_q;
    fc1_d = fc1_q;
    tc_d = tc_q;
    rdy = 1'b0;
    take = 1'b0;
    trunc = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: if (enable & (src0_valid | src1_valid)) begin
        grant_d = {win1, ~win1};
        last_d = win1;
        wc_d = '0;
        state_d = SEND;
      end
      SEND: begin
        rdy = ~tx_stop;
        take = sel_valid & ~tx_stop;
        if (take) begin
          wc_d = wc_q + 1'b1;
          done = sel_eof != 4'd0;
          trunc = ~done & (wc_q == WW'(MAX_WORDS - 1));
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        done = sel_valid & (sel_eof != 4'd0);
      end
      default: state_d = IDLE;
    endcase
    if (trunc) begin
      tc_d = tc_q + {7'd0, tc_q != 8'hff};
      state_d = DRAIN;
    end
    if (done) begin
      fc0_d = fc0_q + {15'd0, ~sel};
      fc1_d = fc1_q + {15'd0, sel};
      grant_d = 2'b00;
      state_d = IDLE;
    end
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q <= 1'b1;
      wc_q <= '0;
      fc0_q <= '0;
      fc1_q <= '0;
      tc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      wc_q <= wc_d;
      fc0_q <= fc0_d;
      fc1_q <= fc1_d;
      tc_q <= tc_d;
    end
  end
  assign src0_ready = rdy & grant_q[0];
  assign src1_ready = rdy & grant_q[1];
  assign tx_we = take & (state_q == SEND);
  assign tx_data = sel_data;
  assign tx_eof = trunc ? FORCE_EOF : sel_eof;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
  assign frame_cnt0 = fc0_q;
  assign frame_cnt1 = fc1_q;
  assign trunc_cnt = tc_q;
endmodule

// File: tb/tb_tx_stream_arb.sv
// tb_tx_stream_arb: randomized frame-level check of tx_stream_arb against a word-index reference model
module tb_tx_stream_arb;
  localparam int MAXW = 8;
  localparam logic [3:0] FEOF = 4'b0001;
  localparam int NF = 40;
  logic clk = 0, reset = 1, enable = 1, strict_prio = 0, tx_stop = 0;
  logic [31:0] s_data [2];
  logic [3:0] s_eof [2];
  logic s_valid [2];
  logic [1:0] rdy, grant;
  logic [31:0] tx_data;
  logic [3:0] tx_eof;
  logic tx_we, busy;
  logic [15:0] frame_cnt0, frame_cnt1;
  logic [7:0] trunc_cnt;
  logic [31:0] wd [2][NF][12];
  logic [3:0] we [2][NF][12];
  int wl [2][NF];
  int lim [2];
  int vprob = 70, sprob = 0;
  int checks = 0, errors = 0;
  bit mon_on = 0;
  int own = -1, k = 0, last = 1, tc = 0;
  int fi [2], fc [2];
  logic [1:0] exp_g = 0;
  tx_stream_arb #(.MAX_WORDS(MAXW), .FORCE_EOF(FEOF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .strict_prio(strict_prio),
    .src0_data(s_data[0]), .src0_eof(s_eof[0]), .src0_valid(s_valid[0]), .src0_ready(rdy[0]),
    .src1_data(s_data[1]), .src1_eof(s_eof[1]), .src1_valid(s_valid[1]), .src1_ready(rdy[1]),
    .tx_data(tx_data), .tx_eof(tx_eof), .tx_we(tx_we), .tx_stop(tx_stop),
    .grant(grant), .busy(busy), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .trunc_cnt(trunc_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input int s);
    int f = 0, w = 0;
    forever begin
      @(posedge clk);
      #1;
      s_valid[s] = (f < lim[s]) && ($urandom_range(99) < vprob);
      s_data[s] = (f < lim[s]) ? wd[s][f][w] : 32'h0;
      s_eof[s] = (f < lim[s]) ? we[s][f][w] : 4'h0;
      @(negedge clk);
      if (s_valid[s] && rdy[s]) begin
        w++;
        if (w == wl[s][f]) begin
          w = 0;
          f++;
        end
      end
    end
  endtask
  initial drive(0);
  initial drive(1);
  initial forever begin
    @(posedge clk);
    #1;
    tx_stop = $urandom_range(99) < sprob;
  end
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      logic [1:0] v;
      logic er, fire, drain;
      int o, f;
      check("frame_cnt0", frame_cnt0, fc[0] & 32'hffff);
      check("frame_cnt1", frame_cnt1, fc[1] & 32'hffff);
      check("trunc_cnt", trunc_cnt, tc);
      if (own < 0) begin
        check("grant_arb", grant, exp_g);
        check("busy_idle", busy, exp_g != 0);
        if (exp_g != 0) begin
          own = exp_g[1] ? 1 : 0;
          last = own;
          k = 0;
        end
      end
      if (own < 0) begin
        check("ready_idle", rdy, 2'b00);
        check("we_idle", tx_we, 1'b0);
        v = {s_valid[1], s_valid[0]};
        exp_g = (!enable || v == 2'b00) ? 2'b00 : (v != 2'b11) ? v : (strict_prio || last == 1) ? 2'b01 : 2'b10;
      end else begin
        o = own;
        f = fi[o];
        drain = k >= MAXW;
        er = drain ? 1'b1 : !tx_stop;
        check("grant_hold", grant, o ? 2'b10 : 2'b01);
        check("busy", busy, 1'b1);
        check("ready", rdy, er ? (o ? 2'b10 : 2'b01) : 2'b00);
        fire = s_valid[o] && er;
        check("tx_we", tx_we, fire && !drain);
        if (fire && !drain) begin
          check("tx_data", tx_data, wd[o][f][k]);
          check("tx_eof", tx_eof, (k == MAXW - 1 && k != wl[o][f] - 1) ? FEOF : we[o][f][k]);
        end
        if (fire) begin
          if (k == MAXW - 1 && k != wl[o][f] - 1 && tc < 255) tc++;
          if (k == wl[o][f] - 1) begin
            fc[o]++;
            fi[o]++;
            own = -1;
            exp_g = 2'b00;
          end
          k++;
        end
      end
    end
  end
  initial begin
    int p;
    for (int s = 0; s < 2; s++) begin
      s_valid[s] = 0;
      s_data[s] = 0;
      s_eof[s] = 0;
      lim[s] = 0;
      fi[s] = 0;
      fc[s] = 0;
      for (int f = 0; f < NF; f++) begin
        wl[s][f] = $urandom_range(1, 12);
        for (int w = 0; w < 12; w++) begin
          wd[s][f][w] = $urandom;
          we[s][f][w] = (w == wl[s][f] - 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", rdy, 2'b00);
    check("rst_we", tx_we, 1'b0);
    check("rst_cnts", {frame_cnt0, frame_cnt1}, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    mon_on = 1;
    sprob = 20;
    lim[0] = 20;
    lim[1] = 20;
    for (int i = 0; i < 5000 && !(fi[0] >= 20 && fi[1] >= 20); i++) @(posedge clk);
    check("rr_done", fi[0] >= 20 && fi[1] >= 20, 1'b1);
    strict_prio = 1;
    vprob = 100;
    p = fc[1];
    lim[0] = 30;
    lim[1] = 30;
    for (int i = 0; i < 5000 && fi[0] < 30; i++) @(posedge clk);
    check("prio_done", fi[0] >= 30, 1'b1);
    check("prio_src1_frames", frame_cnt1, p & 32'hffff);
    @(posedge clk);
    #1;
    strict_prio = 0;
    sprob = 0;
    enable = 0;
    lim[0] = 40;
    lim[1] = 40;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("en_off_grant", grant, 2'b00);
    check("en_off_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    enable = 1;
    sprob = 20;
    vprob = 70;
    for (int i = 0; i < 5000 && !(own >= 0 && k == 2); i++) @(negedge clk);
    check("mid_frame_seen", own >= 0 && k == 2, 1'b1);
    reset = 1;
    mon_on = 0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_grant", grant, 2'b00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_cnts", {frame_cnt0, frame_cnt1}, 32'h0);
    check("mrst_trunc", trunc_cnt, 8'h0);
    check("mrst_we", tx_we, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
